alu_issue_decode: RTL and testbench
===================================

// Module: alu_issue_decode
// PURPOSE
//  Drives the ALU operand/opcode interface (a, b, alu_op) from a decoded RV64I instruction.
//  Takes instruction, PC and register-file read data via valid/ready.
//  Emits registered ALU operands and the 4-bit alu_op one cycle later through a 2-entry skid buffer.
//  Sits between register read and the execute-stage ALU.
// PARAMETERS
//  XLEN      64  datapath width; only 64 is supported
//  USE_SKID  1   1: 2-entry skid, in_ready registered; 0: single stage, in_ready = ~out_valid | out_ready
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     reset, asynchronous, active-high
//  flush           in   1     sync pipeline kill
//  in_valid        in   1     input beat valid
//  in_ready        out  1     input beat accepted when in_valid & in_ready
//  in_inst         in   32    instruction word
//  in_pc           in   64    instruction PC
//  in_rs1          in   64    rs1 read data
//  in_rs2          in   64    rs2 read data
//  out_valid       out  1     output beat valid
//  out_ready       in   1     downstream accepts
//  out_a           out  64    ALU operand a
//  out_b           out  64    ALU operand b
//  out_alu_op      out  4     ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9 ADDW10 SUBW11 SLLW12 SRLW13 SRAW14
//  out_store_data  out  64    rs2 for stores, else 0
//  out_illegal     out  1     unsupported encoding
// BEHAVIOUR
//  Reset
//   - All outputs and both skid entries go to 0.
//   - in_ready=1 after reset.
//   - Reset mid-transfer discards all held beats immediately.
//  Latency: accepted beat appears on out_* at the next clk edge; no bubbles under out_ready=1.
//  Skid
//   - Entry0 drives out_*; entry1 fills when entry0 is held (out_valid & ~out_ready) and a beat is accepted.
//   - in_ready = ~entry1_valid, registered.
//   - Order preserved; no beat dropped or duplicated.
//   - Output fields are stable while out_valid & ~out_ready.
//  Flush: both entries invalidated next edge; a beat presented the same cycle is dropped (flush wins).
//  Decode
//   - OP       a=rs1, b=rs2; f3 000 ADD, or SUB if f7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//              101 SRL, or SRA if f7=0100000; 110 OR; 111 AND.
//   - OP-IMM   a=rs1, b=sext(imm_i); same f3 map, no SUB.
//              Shifts use b=zext(inst[25:20]); SRAI when inst[31:26]=010000.
//   - OP-32    f3 000 ADDW/SUBW, 001 SLLW, 101 SRLW/SRAW.
//   - OP-IMM-32 ADDW (imm_i), SLLW, SRLW/SRAW (b=inst[24:20]).
//   - LUI      a=0, ADD, b=sext({inst[31:12],12'b0}).
//   - AUIPC    a=pc, ADD, b=sext({inst[31:12],12'b0}).
//   - LOAD     a=rs1, b=sext(imm_i), ADD.
//   - STORE    a=rs1, b=sext(imm_s), ADD, out_store_data=rs2.
//  Illegal
//   - Condition: any other opcode/funct combination.
//   - Outputs: out_illegal=1, alu_op=ADD, a=b=0, store_data=0; still flows as a normal beat.
// CONFIGURATION
//  BRANCH_CMP_EN
//   - Defined: BRANCH opcode 1100011 decodes a=rs1, b=rs2.
//       BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; f3 010/011 illegal.
//   - Defined: extra out port out_br_f3[2:0] = inst[14:12] for branch beats, else 0.
//   - Undefined: BRANCH is illegal; no out_br_f3 port.
// TESTING
//  1. addi 0x00A08093, rs1=5 -> next cycle out_valid=1, a=5, b=10, op=0000, illegal=0.
//  2. sraiw 0x4030D09B, rs1=0x80000000 -> b=3, op=1110.
//     lui 0x800000B7 -> a=0, b=0xFFFFFFFF80000000, op=0000.
//  3. Backpressure: out_ready=0, 3 back-to-back beats
//     -> beats 1,2 accepted, in_ready=0 during beat 3;
//     out_ready=1 -> outputs 1,2,3 in order, none lost.
//  4. flush while both entries full -> next cycle out_valid=0, in_ready=1;
//     concurrent in_valid beat never appears.
//  5. inst 0xFFFFFFFF -> out_illegal=1, op=0000, a=b=0.
//     With BRANCH_CMP_EN, bltu 0x0020E063 -> op=0110, out_br_f3=110.
//  6. rst asserted asynchronously mid-cycle with out_valid=1
//     -> out_valid=0 before next edge; first beat after release decodes correctly.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between register read and the ALU issue stage.
// The out_br_f3 field exists only when BRANCH_CMP_EN is defined.
interface alu_issue_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_store_data;
  logic            out_illegal;
`ifdef BRANCH_CMP_EN
  logic [2:0]      out_br_f3;
`endif

  // Producer of instructions / consumer of ALU beats.
  modport master (
    output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_store_data, out_illegal
`ifdef BRANCH_CMP_EN
    , input out_br_f3
`endif
  );

  // The issue-decode stage itself.
  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_store_data, out_illegal
`ifdef BRANCH_CMP_EN
    , output out_br_f3
`endif
  );
endinterface

// File: rtl/alu_issue_decode.sv
// ALU issue decode: turns an RV64I instruction plus register read data into
// registered ALU operands and a 4-bit alu_op, buffered by a 2-entry skid
// (USE_SKID=1) or a single pipeline stage (USE_SKID=0).
// Optional feature macro: BRANCH_CMP_EN (branch compare decode + out_br_f3).
// Only XLEN=64 is meaningful; the immediates assume a 64-bit datapath.
module alu_issue_decode #(
  parameter int XLEN     = 64,
  parameter int USE_SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_ADDW = 4'd10,
    ALU_SUBW = 4'd11,
    ALU_SLLW = 4'd12,
    ALU_SRLW = 4'd13,
    ALU_SRAW = 4'd14
  } alu_op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
`ifdef BRANCH_CMP_EN
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
`endif
  localparam logic [6:0] F7_ZERO       = 7'b0000000;
  localparam logic [6:0] F7_ALT        = 7'b0100000;

  // One buffered ALU beat.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [XLEN-1:0] sd;
    logic            ill;
`ifdef BRANCH_CMP_EN
    logic [2:0]      br_f3;
`endif
  } beat_t;

  // funct3 map shared by OP and OP-IMM (SUB/SRA handled by the caller).
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;

  assign inst   = bus.in_inst;
  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};

  beat_t dec;
  logic  illegal;

  // Combinational decode of the presented instruction into an ALU beat.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.a = bus.in_rs1;
        dec.b = bus.in_rs2;
        if (f7 == F7_ZERO)                      dec.op = base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)  dec.op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)  dec.op = ALU_SRA;
        else                                    illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a = bus.in_rs1;
        dec.b = imm_i;
        case (f3)
          3'b001: begin
            dec.b  = shamt6;
            dec.op = ALU_SLL;
            if (inst[31:26] != 6'b000000) illegal = 1'b1;
          end
          3'b101: begin
            dec.b = shamt6;
            if (inst[31:26] == 6'b000000)      dec.op = ALU_SRL;
            else if (inst[31:26] == 6'b010000) dec.op = ALU_SRA;
            else                               illegal = 1'b1;
          end
          default: dec.op = base_op(f3);
        endcase
      end
      OPC_OP_32: begin
        dec.a = bus.in_rs1;
        dec.b = bus.in_rs2;
        case (f3)
          3'b000: begin
            if (f7 == F7_ZERO)     dec.op = ALU_ADDW;
            else if (f7 == F7_ALT) dec.op = ALU_SUBW;
            else                   illegal = 1'b1;
          end
          3'b001: begin
            if (f7 == F7_ZERO) dec.op = ALU_SLLW;
            else               illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_ZERO)     dec.op = ALU_SRLW;
            else if (f7 == F7_ALT) dec.op = ALU_SRAW;
            else                   illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        dec.a = bus.in_rs1;
        case (f3)
          3'b000: begin
            dec.b  = imm_i;
            dec.op = ALU_ADDW;
          end
          3'b001: begin
            dec.b = shamt5;
            if (f7 == F7_ZERO) dec.op = ALU_SLLW;
            else               illegal = 1'b1;
          end
          3'b101: begin
            dec.b = shamt5;
            if (f7 == F7_ZERO)     dec.op = ALU_SRLW;
            else if (f7 == F7_ALT) dec.op = ALU_SRAW;
            else                   illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.a  = '0;
        dec.b  = imm_u;
        dec.op = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.a  = bus.in_pc;
        dec.b  = imm_u;
        dec.op = ALU_ADD;
      end
      OPC_LOAD: begin
        // funct3 111 has no RV64I load.
        dec.a  = bus.in_rs1;
        dec.b  = imm_i;
        dec.op = ALU_ADD;
        if (f3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        // Only SB/SH/SW/SD exist.
        dec.a  = bus.in_rs1;
        dec.b  = imm_s;
        dec.op = ALU_ADD;
        dec.sd = bus.in_rs2;
        if (f3[2]) illegal = 1'b1;
      end
`ifdef BRANCH_CMP_EN
      OPC_BRANCH: begin
        dec.a     = bus.in_rs1;
        dec.b     = bus.in_rs2;
        dec.br_f3 = f3;
        case (f3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b10:   dec.op = ALU_SLT;
          2'b11:   dec.op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
`endif
      default: illegal = 1'b1;
    endcase
    // Illegal beats carry a clean ADD with zero operands.
    if (illegal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  logic  e0_valid_q, e0_valid_d;
  logic  e1_valid_q, e1_valid_d;
  beat_t e0_q, e0_d;
  beat_t e1_q, e1_d;
  logic  in_ready_w;
  logic  accept;
  logic  pop;

  assign accept = bus.in_valid & in_ready_w & ~flush;
  assign pop    = e0_valid_q & bus.out_ready;

  // Skid next state: entry0 is the output stage, entry1 catches a beat accepted while entry0 stalls.
  always_comb begin
    e0_valid_d = e0_valid_q;
    e1_valid_d = e1_valid_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    if (flush) begin
      e0_valid_d = 1'b0;
      e1_valid_d = 1'b0;
    end else if (!e0_valid_q || pop) begin
      if (e1_valid_q) begin
        // in_ready was low, so no new beat can arrive this cycle.
        e0_valid_d = 1'b1;
        e0_d       = e1_q;
        e1_valid_d = 1'b0;
      end else begin
        e0_valid_d = accept;
        if (accept) e0_d = dec;
      end
    end else if (accept) begin
      e1_valid_d = 1'b1;
      e1_d       = dec;
    end
  end

  // Entry state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      e0_valid_q <= e0_valid_d;
      e1_valid_q <= e1_valid_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end

  generate
    if (USE_SKID != 0) begin : g_skid
      logic in_ready_q;
      logic in_ready_d;

      // Registered ready: open whenever entry1 will be empty next cycle.
      always_comb begin
        in_ready_d = ~e1_valid_d;
      end

      // Ready register comes out of reset open.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= in_ready_d;
      end

      assign in_ready_w = in_ready_q;
    end else begin : g_single
      // Single stage: entry1 is never filled because ready tracks the output directly.
      assign in_ready_w = ~e0_valid_q | bus.out_ready;
    end
  endgenerate

  assign bus.in_ready       = in_ready_w;
  assign bus.out_valid      = e0_valid_q;
  assign bus.out_a          = e0_q.a;
  assign bus.out_b          = e0_q.b;
  assign bus.out_alu_op     = e0_q.op;
  assign bus.out_store_data = e0_q.sd;
  assign bus.out_illegal    = e0_q.ill;
`ifdef BRANCH_CMP_EN
  assign bus.out_br_f3      = e0_q.br_f3;
`endif

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed, table-driven bench for alu_issue_decode plus hand-written
// backpressure, flush and asynchronous-reset sequences.
module tb_alu_issue_decode;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  alu_issue_if #(.XLEN(64)) bus ();

  alu_issue_decode #(.XLEN(64), .USE_SKID(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] sd;
    logic        ill;
    logic [2:0]  br;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] RS1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RS2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [31:0] ADDI0 = 32'h0000_8093; // addi x1,x1,0

  task automatic add(input string nm, input logic [31:0] inst, input logic [63:0] pc,
                     input logic [63:0] rs1, input logic [63:0] rs2,
                     input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                     input logic [63:0] sd, input logic ill, input logic [2:0] br);
    vec_t v;
    v.name = nm; v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.op = op; v.sd = sd; v.ill = ill; v.br = br;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] rs1, input logic [63:0] rs2);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.in_pc = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.out_ready = 1'b0;

    //   name      inst          pc              rs1                   rs2  a                     b                     op     sd   ill  br
    add("addi",   32'h00A08093, 64'h0,          64'd5,                64'h0, 64'd5,               64'd10,               4'd0,  64'h0, 1'b0, 3'd0);
    add("sraiw",  32'h4030D09B, 64'h0,          64'h8000_0000,        64'h0, 64'h8000_0000,       64'd3,                4'd14, 64'h0, 1'b0, 3'd0);
    add("lui",    32'h800000B7, 64'h0,          RS1,                  RS2,   64'h0,               64'hFFFF_FFFF_8000_0000, 4'd0, 64'h0, 1'b0, 3'd0);
    add("auipc",  32'h00001097, 64'h8000_0000,  RS1,                  RS2,   64'h8000_0000,       64'h1000,             4'd0,  64'h0, 1'b0, 3'd0);
    add("sub",    32'h40208033, 64'h0,          RS1,                  RS2,   RS1,                 RS2,                  4'd1,  64'h0, 1'b0, 3'd0);
    add("sw",     32'h0020A223, 64'h0,          RS1,                  RS2,   RS1,                 64'd4,                4'd0,  RS2,   1'b0, 3'd0);
    add("ld_neg", 32'hFF813083, 64'h0,          RS1,                  RS2,   RS1,                 64'hFFFF_FFFF_FFFF_FFF8, 4'd0, 64'h0, 1'b0, 3'd0);
    add("srai",   32'h4050D093, 64'h0,          RS1,                  RS2,   RS1,                 64'd5,                4'd9,  64'h0, 1'b0, 3'd0);
    add("srli33", 32'h0210D093, 64'h0,          RS1,                  RS2,   RS1,                 64'd33,               4'd8,  64'h0, 1'b0, 3'd0);
    add("slti",   32'hFFF0A093, 64'h0,          RS1,                  RS2,   RS1,                 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 64'h0, 1'b0, 3'd0);
    add("andi",   32'h0FF0F093, 64'h0,          RS1,                  RS2,   RS1,                 64'hFF,               4'd2,  64'h0, 1'b0, 3'd0);
    add("sltu",   32'h0020B033, 64'h0,          RS1,                  RS2,   RS1,                 RS2,                  4'd6,  64'h0, 1'b0, 3'd0);
    add("sllw",   32'h002090BB, 64'h0,          RS1,                  RS2,   RS1,                 RS2,                  4'd12, 64'h0, 1'b0, 3'd0);
    add("ones",   32'hFFFFFFFF, 64'h1234,       RS1,                  RS2,   64'h0,               64'h0,                4'd0,  64'h0, 1'b1, 3'd0);
    add("mul",    32'h02208033, 64'h0,          RS1,                  RS2,   64'h0,               64'h0,                4'd0,  64'h0, 1'b1, 3'd0);
    add("slli_b", 32'h04109093, 64'h0,          RS1,                  RS2,   64'h0,               64'h0,                4'd0,  64'h0, 1'b1, 3'd0);
    add("sd_bad", 32'h0020C223, 64'h0,          RS1,                  RS2,   64'h0,               64'h0,                4'd0,  64'h0, 1'b1, 3'd0);
`ifdef BRANCH_CMP_EN
    add("bltu",   32'h0020E063, 64'h0,          RS1,                  RS2,   RS1,                 RS2,                  4'd6,  64'h0, 1'b0, 3'd6);
    add("beq",    32'h00208063, 64'h0,          RS1,                  RS2,   RS1,                 RS2,                  4'd1,  64'h0, 1'b0, 3'd0);
`else
    add("bltu",   32'h0020E063, 64'h0,          RS1,                  RS2,   64'h0,               64'h0,                4'd0,  64'h0, 1'b1, 3'd0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst.out_a",     bus.out_a, 64'd0);
    chk("rst.out_b",     bus.out_b, 64'd0);
    chk("rst.out_alu_op", 64'(bus.out_alu_op), 64'd0);
    chk("rst.out_illegal", 64'(bus.out_illegal), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Decode table, back-to-back beats with out_ready held high
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      chk($sformatf("%s.in_ready", vecs[i].name), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("%s.out_valid", vecs[i].name), 64'(bus.out_valid), 64'd1);
      chk($sformatf("%s.a", vecs[i].name), bus.out_a, vecs[i].a);
      chk($sformatf("%s.b", vecs[i].name), bus.out_b, vecs[i].b);
      chk($sformatf("%s.op", vecs[i].name), 64'(bus.out_alu_op), 64'(vecs[i].op));
      chk($sformatf("%s.sd", vecs[i].name), bus.out_store_data, vecs[i].sd);
      chk($sformatf("%s.ill", vecs[i].name), 64'(bus.out_illegal), 64'(vecs[i].ill));
`ifdef BRANCH_CMP_EN
      chk($sformatf("%s.br_f3", vecs[i].name), 64'(bus.out_br_f3), 64'(vecs[i].br));
`endif
    end
    @(posedge clk);
    #1;
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: three back-to-back beats while stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(ADDI0, 64'h0, 64'd100, 64'h0);
    chk("bp.in_ready0", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp.in_ready1", 64'(bus.in_ready), 64'd1);
    chk("bp.a1", bus.out_a, 64'd100);
    @(negedge clk);
    bus.in_rs1 = 64'd200;
    @(posedge clk); #1;
    chk("bp.in_ready2", 64'(bus.in_ready), 64'd0);
    chk("bp.a_hold1", bus.out_a, 64'd100);
    @(negedge clk);
    bus.in_rs1 = 64'd300;
    @(posedge clk); #1;
    chk("bp.in_ready3", 64'(bus.in_ready), 64'd0);
    chk("bp.valid_hold", 64'(bus.out_valid), 64'd1);
    chk("bp.a_hold2", bus.out_a, 64'd100);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.a2", bus.out_a, 64'd200);
    chk("bp.in_ready4", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp.a3", bus.out_a, 64'd300);
    chk("bp.valid3", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp.empty", 64'(bus.out_valid), 64'd0);

    // Flush with both entries full and a third beat pending
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(ADDI0, 64'h0, 64'd7, 64'h0);
    @(posedge clk);
    @(negedge clk);
    bus.in_rs1 = 64'd8;
    @(posedge clk); #1;
    chk("fl.full_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.in_rs1 = 64'd9;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("fl.out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("fl.quiet%0d", k), 64'(bus.out_valid), 64'd0);
    end

    // Flush wins over a beat accepted in the same cycle with ready high
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(ADDI0, 64'h0, 64'd11, 64'h0);
    @(posedge clk); #1;
    chk("fw.held", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.in_rs1 = 64'd12;
    flush = 1'b1;
    chk("fw.ready_before", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("fw.out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fw.quiet", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-cycle with both entries holding beats
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(ADDI0, 64'h0, 64'd21, 64'h0);
    @(posedge clk);
    @(negedge clk);
    bus.in_rs1 = 64'd22;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ar.pre_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar.out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar.out_a", bus.out_a, 64'd0);
    chk("ar.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(32'h00A08093, 64'h0, 64'd5, 64'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ar.post_valid", 64'(bus.out_valid), 64'd1);
    chk("ar.post_a", bus.out_a, 64'd5);
    chk("ar.post_b", bus.out_b, 64'd10);
    chk("ar.post_op", 64'(bus.out_alu_op), 64'd0);
    @(posedge clk); #1;
    chk("ar.no_stale", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
